// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Latency: n/a (definitions only). Backpressure: n/a.
// Contents: XLEN, counter width, funct3 op encodings, FSM state encoding, magnitude helper.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct read as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/response bundle between the EX stage and the multiply/divide sequencer.
// Latency: n/a (wires only). Backpressure: busy stalls the issuer; start is dropped while busy.
// Signals: start/op/data1/data2/flush (issuer -> unit), busy/done/result (unit -> issuer).
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, data1, data2, flush, input busy, done, result);
  modport slave  (input start, op, data1, data2, flush, output busy, done, result);

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: conditional add + right shift (mul), or trial subtract + left shift (div).
// Latency: combinational. Backpressure: none.
// Ports: is_div_i selects engine, acc_i/acc_o = {hi,lo} working register, opnd_i = multiplicand/divisor.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  always_comb begin
    // Multiply: lo holds the remaining multiplier bits; its LSB gates the add into hi.
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} +
              (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    // Divide: partial remainder shifted left by one, pulling in the next dividend bit.
    rem_sh  = acc_i[2*XLEN-1:XLEN-1];
    trial   = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      // Bit XLEN of the trial difference is the borrow: set means the divisor did not fit.
      if (!trial[XLEN]) acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else              acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M mul/div sequencer: magnitudes in, XLEN iterations, sign fix-up on exit.
// Latency: done 33 cycles after accept (1 cycle for div-by-zero / signed overflow). Backpressure: busy; start ignored while busy.
// Ports: clk_i, rst_i (async active-high), bus (muldiv_if.slave: start/op/data1/data2/flush -> busy/done/result).
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  muldiv_if.slave  bus
);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_q;     // negate product / quotient
  logic              neg_r_q;   // negate remainder (dividend sign)
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // Accept-time decode.
  logic            sgn_a, sgn_b, is_div_d, special_d;
  logic [XLEN-1:0] a_mag_d, b_mag_d, special_res_d;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (bus.op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sgn_a = bus.data1[XLEN-1];
        sgn_b = bus.data2[XLEN-1];
      end
      OP_MULHSU: sgn_a = bus.data1[XLEN-1];
      default: ;
    endcase
    a_mag_d  = mag(bus.data1, sgn_a);
    b_mag_d  = mag(bus.data2, sgn_b);
    is_div_d = bus.op[2];
    special_d     = 1'b0;
    special_res_d = '0;
    if (is_div_d && (bus.data2 == '0)) begin
      special_d = 1'b1;
      special_res_d = bus.op[1] ? bus.data1 : '1;    // op[1] distinguishes REM* from DIV*
    end else if ((bus.op == OP_DIV || bus.op == OP_REM) &&
                 (bus.data1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.data2 == '1)) begin
      special_d = 1'b1;
      special_res_d = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  logic [2*XLEN-1:0] acc_d;

  muldiv_step u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d)
  );

  // Final result taken straight from the last iteration so it registers on the same edge as done.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result_d;

  always_comb begin
    prod_fix = neg_q ? (~acc_d + 1'b1) : acc_d;
    quo_fix  = mag(acc_d[XLEN-1:0], neg_q);
    rem_fix  = mag(acc_d[2*XLEN-1:XLEN], neg_r_q);
    case (op_q)
      OP_MUL:          result_d = prod_fix[XLEN-1:0];
      OP_DIV, OP_DIVU: result_d = quo_fix;
      OP_REM, OP_REMU: result_d = rem_fix;
      default:         result_d = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q    <= bus.op;
            cnt_q   <= '0;
            neg_q   <= sgn_a ^ sgn_b;
            neg_r_q <= sgn_a;
            busy_q  <= 1'b1;
            // mul: lo = multiplier, add multiplicand; div: lo = dividend, subtract divisor.
            acc_q   <= {{XLEN{1'b0}}, is_div_d ? a_mag_d : b_mag_d};
            opnd_q  <= is_div_d ? b_mag_d : a_mag_d;
            if (special_d) begin
              state_q  <= ST_FINISH;
              done_q   <= 1'b1;
              result_q <= special_res_d;
            end else begin
              state_q  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
              state_q  <= ST_FINISH;
              done_q   <= 1'b1;
              result_q <= result_d;
            end
          end
        end
        default: begin
          // FINISH (flush or not) and any illegal encoding return to IDLE.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed RV32M results, latency, busy, flush and reset.
// Latency counted in rising edges from the accept edge (inclusive) to the first sample with done.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if bus();

  muldiv_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 0;
  int busy_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step_cyc();
    @(posedge clk);
    lat++;
    @(negedge clk);
    if (bus.busy) busy_cnt++;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.data1 = a;
    bus.data2 = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.data1 = 32'hDEAD_BEEF;   // must not matter once accepted
    bus.data2 = 32'h0000_0001;
    busy_cnt = bus.busy ? 1 : 0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    while (!bus.done && lat < 100) step_cyc();
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, bus.result, exp_res);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    step_cyc();
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_hold"}, bus.result, exp_res);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    start_op(op, a, b);
    wait_done(tag, exp_res, exp_lat);
  endtask

  logic seen_done;

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.flush = 1'b0;

    // Reset state
    #12;
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1. Signed low multiply
    do_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    // 2. High halves with all-ones operands
    do_op("mulhu", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("mulh",  OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    do_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

    // 3. Division
    do_op("div_m7_2", OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem_m7_2", OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

    // 4. Special cases bypass the iterations
    do_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    do_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // 5a. START while busy is dropped
    start_op(OP_MUL, 32'd6, 32'd7);
    while (lat < 10) step_cyc();
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.data1 = 32'd100;
    bus.data2 = 32'd3;
    step_cyc();
    bus.start = 1'b0;
    wait_done("start_busy", 32'd42, 33);

    // 5b. FLUSH mid-calculation
    start_op(OP_MUL, 32'd3, 32'd5);
    while (lat < 20) step_cyc();
    bus.flush = 1'b1;
    step_cyc();
    bus.flush = 1'b0;
    chk("flush_busy",   {31'd0, bus.busy}, 32'd0);
    chk("flush_done",   {31'd0, bus.done}, 32'd0);
    chk("flush_result", bus.result, 32'd42);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_cyc();
      seen_done = seen_done | bus.done;
    end
    chk("flush_no_done", {31'd0, seen_done}, 32'd0);

    // 5c. FLUSH together with START in IDLE: nothing accepted
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.data1 = 32'd2;
    bus.data2 = 32'd2;
    bus.flush = 1'b1;
    step_cyc();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", {31'd0, bus.busy}, 32'd0);
    step_cyc();
    chk("flush_start_done", {31'd0, bus.done}, 32'd0);

    // 6. Asynchronous reset mid-calculation
    start_op(OP_MUL, 32'd3, 32'd5);
    while (lat < 15) step_cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("arst_done",   {31'd0, bus.done}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step_cyc();
      seen_done = seen_done | bus.done;
    end
    chk("arst_no_done", {31'd0, seen_done}, 32'd0);
    do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
